// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
// mem_arb_pkg: shared types and default widths for the unified memory port
// arbiter (IF fetch vs. DM load/store). Imported by mem_port_arbiter and
// arb_timeout_ctr.
package mem_arb_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_timeout_ctr.sv
`timescale 1ns/1ps
// arb_timeout_ctr: response watchdog for the memory port arbiter. Cleared when
// an access is granted, counts while enabled, and raises o_expired once the
// count reaches TIMEOUT-1 (it then holds there until the next clear).
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count waiting cycles; stop at the terminal value so the flag stays stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares the single memory port between instruction fetch
// (IF) and the load/store unit (DM), one outstanding access at a time.
// DM has priority, but after MAX_DM_RUN back-to-back DM grants with IF waiting,
// IF is forced through. A response watchdog aborts silent accesses and sets a
// sticky err flag. Optional macro MEM_ARB_PERF_EN adds stall/transfer counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]     if_stall_cnt,
  output logic [31:0]     dm_stall_cnt,
  output logic [31:0]     xfer_cnt,
`endif
  output logic            err
);

  localparam int BW    = DW / 8;
  localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

  arb_state_e       r_state;
  arb_state_e       w_nextState;
  arb_owner_e       w_owner;
  logic             w_ifWin;
  logic             w_gntOk;
  logic             w_ifGnt;
  logic             w_dmGnt;
  logic             w_waiting;
  logic             w_respOk;
  logic             w_timeout;
  logic             w_done;
  logic             w_expired;

  logic             r_memReq;
  logic             r_memWe;
  logic [AW-1:0]    r_memAddr;
  logic [DW-1:0]    r_memWdata;
  logic [BW-1:0]    r_memBe;
  logic             r_ifRvalid;
  logic             r_dmRvalid;
  logic [DW-1:0]    r_ifRdata;
  logic [DW-1:0]    r_dmRdata;
  logic             r_err;
  logic [RUN_W-1:0] r_dmRun;

  // IF wins alone, or when DM has already used up its run while IF waited.
  assign w_ifWin = if_req && (!dm_req || (r_dmRun == RUN_MAX));
  // The cycle carrying a response pulse is already IDLE but must not grant,
  // which keeps grant-to-grant spacing at four cycles.
  assign w_gntOk = !r_ifRvalid && !r_dmRvalid;

  assign w_waiting = (r_state == WAIT_IF) || (r_state == WAIT_DM);
  assign w_owner   = (r_state == WAIT_DM) ? OWN_DM : OWN_IF;
  // A response is only accepted once mem_req has been presented to memory.
  assign w_respOk  = w_waiting && !r_memReq && mem_rvalid;
  assign w_timeout = w_waiting && !w_respOk && w_expired;
  assign w_done    = w_respOk || w_timeout;

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_ifGnt || w_dmGnt),
    .i_en      (w_waiting),
    .o_expired (w_expired)
  );

  // Next-state and grant decode: grants only from IDLE, only to the winner.
  always_comb begin
    w_nextState = r_state;
    w_ifGnt     = 1'b0;
    w_dmGnt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gntOk) begin
          if (w_ifWin) begin
            w_ifGnt     = 1'b1;
            w_nextState = WAIT_IF;
          end else if (dm_req) begin
            w_dmGnt     = 1'b1;
            w_nextState = WAIT_DM;
          end
        end
      end
      WAIT_IF, WAIT_DM: begin
        if (w_done) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the granted request into the memory port; mem_req is a one-cycle pulse.
  // Fetches are full-word reads, so they drive all byte enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memBe    <= '0;
    end else begin
      r_memReq <= w_ifGnt || w_dmGnt;
      if (w_ifGnt) begin
        r_memWe    <= 1'b0;
        r_memAddr  <= if_addr;
        r_memWdata <= '0;
        r_memBe    <= '1;
      end else if (w_dmGnt) begin
        r_memWe    <= dm_we;
        r_memAddr  <= dm_addr;
        r_memWdata <= dm_wdata;
        r_memBe    <= dm_be;
      end
    end
  end

  // Route the response (or a zero on timeout) to the owner; rdata holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifRvalid <= 1'b0;
      r_dmRvalid <= 1'b0;
      r_ifRdata  <= '0;
      r_dmRdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ifRvalid <= w_done && (w_owner == OWN_IF);
      r_dmRvalid <= w_done && (w_owner == OWN_DM);
      if (w_done && (w_owner == OWN_IF)) begin
        r_ifRdata <= w_respOk ? mem_rdata : '0;
      end
      if (w_done && (w_owner == OWN_DM)) begin
        r_dmRdata <= w_respOk ? mem_rdata : '0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Track consecutive DM grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dmRun <= '0;
    end else if (w_ifGnt) begin
      r_dmRun <= '0;
    end else if (w_dmGnt) begin
      if (!if_req) begin
        r_dmRun <= '0;
      end else if (r_dmRun != RUN_MAX) begin
        r_dmRun <= r_dmRun + RUN_W'(1);
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_ifStallCnt;
  logic [31:0] r_dmStallCnt;
  logic [31:0] r_xferCnt;

  // Free-running wrapping counters for stalls and completed transactions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifStallCnt <= '0;
      r_dmStallCnt <= '0;
      r_xferCnt    <= '0;
    end else begin
      if (if_req && !w_ifGnt) r_ifStallCnt <= r_ifStallCnt + 32'd1;
      if (dm_req && !w_dmGnt) r_dmStallCnt <= r_dmStallCnt + 32'd1;
      if (w_done)             r_xferCnt    <= r_xferCnt + 32'd1;
    end
  end

  assign if_stall_cnt = r_ifStallCnt;
  assign dm_stall_cnt = r_dmStallCnt;
  assign xfer_cnt     = r_xferCnt;
`endif

  assign if_gnt    = w_ifGnt;
  assign dm_gnt    = w_dmGnt;
  assign if_rvalid = r_ifRvalid;
  assign if_rdata  = r_ifRdata;
  assign dm_rvalid = r_dmRvalid;
  assign dm_rdata  = r_dmRdata;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_be    = r_memBe;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: directed stimulus with a scoreboard. Each issued
// transaction pushes its expected grant, memory request and response; one
// monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] ifStallCnt;
  logic [31:0] dmStallCnt;
  logic [31:0] xferCnt;
`endif

  typedef struct {
    bit isDm;
    int gap;
  } gnt_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } memtx_t;

  typedef struct {
    bit          isDm;
    logic [31:0] data;
    int          lat;
  } resp_t;

  gnt_t   gntQ[$];
  memtx_t memQ[$];
  resp_t  respQ[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lastGnt = 0;
  int memReqCycle = 0;
  int memLatency = 1;

  mem_port_arbiter #(
    .AW         (32),
    .DW         (32),
    .MAX_DM_RUN (4),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_be      (dm_be),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
`ifdef MEM_ARB_PERF_EN
    .if_stall_cnt (ifStallCnt),
    .dm_stall_cnt (dmStallCnt),
    .xfer_cnt     (xferCnt),
`endif
    .err        (err)
  );

  // Clock: rising edges at 10, 20, 30 ns ...
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5 clk = 1'b0;
      #5;
    end
  end

  // Cycle index used for latency and spacing measurements.
  always @(posedge clk) cycle <= cycle + 1;

  // Memory contents seen by the model.
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return a ^ 32'hA5A5A5A5;
  endfunction

  // Memory model: answers each mem_req after memLatency cycles.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        repeat (memLatency) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = memData(mem_addr);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL unexpected_%s: got an event, expected none", name);
  endtask

  task automatic applyStimulus(input bit ifReq, input logic [31:0] ifAddr, input bit dmReq,
                               input bit dmWe, input logic [31:0] dmAddr,
                               input logic [31:0] dmWdata, input logic [3:0] dmBe);
    if_req   = ifReq;
    if_addr  = ifAddr;
    dm_req   = dmReq;
    dm_we    = dmWe;
    dm_addr  = dmAddr;
    dm_wdata = dmWdata;
    dm_be    = dmBe;
  endtask

  task automatic expectTxn(input bit isDm, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] data, input int lat, input int gap);
    gnt_t   g;
    memtx_t m;
    resp_t  r;
    g.isDm = isDm; g.gap = gap;
    gntQ.push_back(g);
    m.we = we; m.addr = addr; m.wdata = wdata; m.be = be;
    memQ.push_back(m);
    if (lat >= 0) begin
      r.isDm = isDm; r.data = data; r.lat = lat;
      respQ.push_back(r);
    end
  endtask

  task automatic waitGnt(input bit isDm, output int waited);
    waited = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (isDm ? dm_gnt : if_gnt) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_wait: got no grant in 200 cycles, expected %s grant", isDm ? "dm" : "if");
    end
  endtask

  task automatic issueSingle(input bit isDm, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, output int waited);
    if (isDm) applyStimulus(1'b0, '0, 1'b1, we, addr, wdata, be);
    else      applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, '0, '0);
    waitGnt(isDm, waited);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((respQ.size() != 0 || gntQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d responses outstanding, expected 0", respQ.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a grant, mem_req or response appears.
  initial begin
    bit     prevGnt;
    gnt_t   g;
    memtx_t m;
    resp_t  r;
    prevGnt = 1'b0;
    forever begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        if (gntQ.size() == 0) unexpected("gnt");
        else begin
          g = gntQ.pop_front();
          checkOutput("gnt_owner", 64'({if_gnt, dm_gnt}), g.isDm ? 64'd1 : 64'd2);
          if (g.gap >= 0) checkOutput("gnt_spacing", 64'(cycle - lastGnt), 64'(g.gap));
        end
        lastGnt = cycle;
      end
      if (mem_req) begin
        if (memQ.size() == 0) unexpected("mem_req");
        else begin
          m = memQ.pop_front();
          checkOutput("mem_addr", 64'(mem_addr), 64'(m.addr));
          checkOutput("mem_we_be_wdata", 64'({mem_we, mem_be, mem_wdata}), 64'({m.we, m.be, m.wdata}));
          checkOutput("mem_req_after_gnt", 64'(prevGnt), 64'd1);
        end
        memReqCycle = cycle;
      end
      prevGnt = if_gnt || dm_gnt;
      if (if_rvalid || dm_rvalid) begin
        if (respQ.size() == 0) unexpected("rvalid");
        else begin
          r = respQ.pop_front();
          checkOutput("resp_owner", 64'({if_rvalid, dm_rvalid}), r.isDm ? 64'd1 : 64'd2);
          checkOutput("resp_data", 64'(r.isDm ? dm_rdata : if_rdata), 64'(r.data));
          checkOutput("resp_latency", 64'(cycle - memReqCycle), 64'(r.lat));
        end
      end
    end
  end

  // Hard stop in case the directed sequence stalls.
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got no finish by 500 us, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int waited;
    int n;
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

    // Reset then idle.
    #12;
    checkOutput("in_reset_outputs",
                64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, err}), 64'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_ctrl", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, err}), 64'd0);
    checkOutput("idle_data", 64'({if_rdata, dm_rdata}), 64'd0);
    checkOutput("idle_mem", 64'({mem_addr, mem_wdata}), 64'd0);

    // IF only, 1-cycle memory.
    $display("[TB] IF-only fetch");
    expectTxn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h00A00093, 2, -1);
    issueSingle(1'b0, 1'b0, 32'h10, '0, '0, waited);
    checkOutput("if_gnt_same_cycle", 64'(waited), 64'd0);
    waitDrain();
    checkOutput("if_rdata_hold", 64'({if_rvalid, if_rdata}), 64'({1'b0, 32'h00A00093}));

    // Simultaneous requests: DM first, IF four cycles later.
    $display("[TB] simultaneous requests");
    expectTxn(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'hA5A5A4A5, 2, -1);
    expectTxn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 32'hA5A5A585, 2, 4);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h100, '0, 4'hF);
    waitGnt(1'b1, waited);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, '0);
    waitGnt(1'b0, waited);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    waitDrain();

    // Store: write fields forwarded, completion returns mem_rdata.
    $display("[TB] store");
    expectTxn(1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011, 32'hA5A5A5E5, 2, -1);
    issueSingle(1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011, waited);
    waitDrain();

    // Starvation guard: four DM grants, one IF, then DM again.
    $display("[TB] starvation guard");
    expectTxn(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'hA5A5A7A5, 2, -1);
    for (int i = 0; i < 3; i++) expectTxn(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'hA5A5A7A5, 2, 4);
    expectTxn(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, 32'hA5A5A595, 2, 4);
    expectTxn(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'hA5A5A7A5, 2, 4);
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h200, '0, 4'hF);
    n = 0;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) n++;
    end
    checkOutput("starve_grants", 64'(n), 64'd6);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    waitDrain();

    // Timeout: memory answers far too late.
    $display("[TB] timeout");
    memLatency = TIMEOUT + 10;
    expectTxn(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0, TIMEOUT, -1);
    issueSingle(1'b1, 1'b0, 32'h300, '0, 4'hF, waited);
    checkOutput("err_before_timeout", 64'(err), 64'd0);
    waited = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm_rvalid) begin
        waited = i;
        break;
      end
    end
    checkOutput("err_at_timeout", 64'({waited >= 0, err}), 64'b11);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("err_sticky", 64'(err), 64'd1);
    memLatency = 1;

    // Reset while in WAIT_DM: access dropped, err cleared.
    $display("[TB] reset mid-access");
    memLatency = 10;
    expectTxn(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, -1, -1);
    issueSingle(1'b1, 1'b0, 32'h400, '0, 4'hF, waited);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_outputs", 64'({dm_rvalid, if_rvalid, mem_req, err, dm_gnt, if_gnt}), 64'd0);
    checkOutput("midreset_data", 64'({dm_rdata, mem_addr}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    memLatency = 1;
    expectTxn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h00A00093, 2, -1);
    issueSingle(1'b0, 1'b0, 32'h10, '0, '0, waited);
    waitDrain();
    checkOutput("err_after_reset", 64'(err), 64'd0);

    checkOutput("leftover_gnt", 64'(gntQ.size()), 64'd0);
    checkOutput("leftover_mem", 64'(memQ.size()), 64'd0);
    checkOutput("leftover_resp", 64'(respQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the RISC-V core between the instruction-fetch stage (IF) and the load/store unit (DM).
- Accepts one request per transaction from either requester and forwards it to memory, allowing one outstanding access.
- Routes the read data back to the requester that issued the access.
- Sits between the fetch/LSU logic and the memory model, under the top-level processor module.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DM_RUN, 4, consecutive DM grants allowed while IF is pending before IF is forced.
- TIMEOUT, 64, cycles to wait for mem_rvalid before aborting the access.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  AW  fetch address.
- if_gnt  output  1  fetch accepted this cycle.
- if_rvalid  output  1  fetch data valid, 1-cycle pulse.
- if_rdata  output  DW  fetch data.
- dm_req  input  1  data request; held until dm_gnt.
- dm_we  input  1  1 = store.
- dm_addr  input  AW  data address.
- dm_wdata  input  DW  store data.
- dm_be  input  DW/8  byte enables.
- dm_gnt  output  1  data accepted this cycle.
- dm_rvalid  output  1  load data or store completion, 1-cycle pulse.
- dm_rdata  output  DW  load data.
- mem_req  output  1  memory request, 1-cycle pulse.
- mem_we, mem_addr, mem_wdata, mem_be  output  1/AW/DW/DW/8  registered copy of the granted request.
- mem_rvalid  input  1  memory response valid.
- mem_rdata  input  DW  memory read data.
- err  output  1  sticky timeout flag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst.
- Reset values: state IDLE; all outputs 0; dm_run counter 0; timer 0. Reset asserted mid-transaction drops the access; no rvalid is produced for it.
- FSM states: IDLE, WAIT_IF, WAIT_DM.
- IDLE arbitration:
  - DM has priority.
  - IF wins when only if_req is high.
  - IF also wins when both are high and dm_run == MAX_DM_RUN.
- Grant timing:
  - if_gnt/dm_gnt are combinational, high only in IDLE, and only for the winner.
  - On the grant edge the request fields are registered into mem_*.
  - mem_req is high for the next cycle only.
  - State moves to WAIT_IF or WAIT_DM.
- dm_run counter:
  - +1 on a DM grant while if_req is high, saturating at MAX_DM_RUN.
  - Cleared on an IF grant.
  - Cleared when a DM grant occurs with if_req low.
- WAIT_x:
  - The timer counts from 0 starting in the cycle after mem_req.
  - On mem_rvalid, x_rvalid is pulsed the next cycle with x_rdata = mem_rdata; x_rdata holds until the next response to x. State returns to IDLE in that same cycle.
  - The earliest new grant is the cycle after return to IDLE.
  - Minimum grant-to-grant spacing is 4 cycles with a 1-cycle memory.
- Timeout: if the timer reaches TIMEOUT-1 without mem_rvalid:
  - x_rvalid pulses with x_rdata = 0.
  - err is set (sticky until reset).
  - State returns to IDLE.
  - A late mem_rvalid arriving in IDLE is ignored.
- Spurious input: mem_rvalid in IDLE is ignored.
- Stores: dm_rvalid pulses on completion; dm_rdata is undefined-but-stable and is driven with mem_rdata.
- Requests dropped before grant are legal. No grant is issued if req is low in IDLE.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds three 32-bit wrapping output counters:
  - if_stall_cnt: cycles with if_req high and if_gnt low.
  - dm_stall_cnt: cycles with dm_req high and dm_gnt low.
  - xfer_cnt: completed transactions, including timeouts.
  - All reset to 0.
- When undefined, these ports and the logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, WAIT_IF, WAIT_DM}.
  - owner encoding (OWN_IF=0, OWN_DM=1).
  - Default AW/DW constants.
- Sub-module arb_timeout_ctr: load/clear, count, and expire flag at TIMEOUT-1; reused for the timer.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Reset then idle: rst low 15 ns, then high, no requests -> all outputs 0, mem_req never asserts.
- IF only, 1-cycle memory, addr 0x10 returning 0x00A00093:
  - if_gnt in the cycle if_req is seen, mem_req the next cycle.
  - if_rvalid one cycle after mem_rvalid with if_rdata = 0x00A00093.
- Simultaneous requests, same cycle: dm_gnt first. IF is granted in the first IDLE after the DM response.
- Starvation guard: dm_req and if_req held high -> exactly 4 DM grants, then 1 IF grant, then the DM run resumes.
- Timeout: memory never responds -> dm_rvalid pulses with dm_rdata = 0 and err = 1 at cycle TIMEOUT after mem_req. A later mem_rvalid is ignored.
- Reset mid-access: rst low while in WAIT_DM -> state IDLE, no dm_rvalid, err = 0. After reset release a new IF request completes normally.
